// File: rtl/alu_pkg.sv
// ALU control encodings and legality check, shared by the ALU and its arbiter.
package alu_pkg;
  localparam int ALU_CTRL_W = 3;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    SLT = 3'b101
  } alu_ctrl_e;

  function automatic logic is_legal_ctrl(input logic [ALU_CTRL_W-1:0] c);
    case (c)
      ADD, SUB, AND, OR, SLT: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, combinational from the requests; last_grant advances only on accept.
// Reset leaves last_grant=1 so port 0 wins the first contention.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic accept,
  output logic gnt0,
  output logic gnt1
);
  logic last_grant;

  assign gnt0 = req0 && (!req1 || last_grant);
  assign gnt1 = req1 && (!req0 || !last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= gnt1;
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters; issue reg -> ALU -> result reg,
// 2-edge latency, 1 op/cycle; rsp_ready low stalls the result then the issue stage, dropping both readys.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s0_valid,
  output logic                  s0_ready,
  input  logic [DATA_WIDTH-1:0] s0_op1,
  input  logic [DATA_WIDTH-1:0] s0_op2,
  input  logic [2:0]            s0_ctrl,
  input  logic                  s1_valid,
  output logic                  s1_ready,
  input  logic [DATA_WIDTH-1:0] s1_op1,
  input  logic [DATA_WIDTH-1:0] s1_op2,
  input  logic [2:0]            s1_ctrl,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_eq,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [2:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_eq
);
  logic                  iss_valid;
  logic                  iss_id;
  logic [DATA_WIDTH-1:0] iss_op1;
  logic [DATA_WIDTH-1:0] iss_op2;
  logic [ALU_CTRL_W-1:0] iss_ctrl;
  logic                  gnt0, gnt1;
  logic                  res_load, iss_load, accept;

  assign res_load = iss_valid && (!rsp_valid || rsp_ready);
  assign iss_load = !iss_valid || res_load;
  // Readys are held low while reset is asserted even though the empty pipe could accept.
  assign s0_ready = rst_n && gnt0 && iss_load;
  assign s1_ready = rst_n && gnt1 && iss_load;
  assign accept   = s0_ready || s1_ready;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (s0_valid),
    .req1   (s1_valid),
    .accept (accept),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  assign alu_op1  = iss_valid ? iss_op1  : '0;
  assign alu_op2  = iss_valid ? iss_op2  : '0;
  assign alu_ctrl = iss_valid ? iss_ctrl : ADD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      iss_id    <= 1'b0;
      iss_op1   <= '0;
      iss_op2   <= '0;
      iss_ctrl  <= ADD;
    end else if (accept) begin
      iss_valid <= 1'b1;
      iss_id    <= s1_ready;
      iss_op1   <= s1_ready ? s1_op1  : s0_op1;
      iss_op2   <= s1_ready ? s1_op2  : s0_op2;
      iss_ctrl  <= s1_ready ? s1_ctrl : s0_ctrl;
    end else if (res_load) begin
      iss_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_eq     <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (res_load) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= iss_id;
      rsp_result <= is_legal_ctrl(iss_ctrl) ? alu_out : '0;
      rsp_eq     <= (iss_ctrl == SUB) ? alu_eq : 1'b0;
      rsp_err    <= !is_legal_ctrl(iss_ctrl);
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: behavioural ALU, queue-based pipeline model checked every cycle,
// plus literal expectations for the hand-computed scenarios.
module tb_alu_arbiter;
  localparam int W = 32;

  typedef struct packed {
    logic         id;
    logic [W-1:0] result;
    logic         eq;
    logic         err;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s0_valid = 1'b0, s1_valid = 1'b0;
  logic [W-1:0] s0_op1 = '0, s0_op2 = '0, s1_op1 = '0, s1_op2 = '0;
  logic [2:0]   s0_ctrl = '0, s1_ctrl = '0;
  logic         rsp_ready = 1'b1;
  logic         s0_ready, s1_ready, rsp_valid, rsp_id, rsp_eq, rsp_err;
  logic [W-1:0] rsp_result, alu_op1, alu_op2, alu_out;
  logic [2:0]   alu_ctrl;
  logic         alu_eq;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_op1(s0_op1), .s0_op2(s0_op2), .s0_ctrl(s0_ctrl),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_op1(s1_op1), .s1_op2(s1_op2), .s1_ctrl(s1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_eq(rsp_eq), .rsp_err(rsp_err),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_eq(alu_eq)
  );

  function automatic logic legal(input logic [2:0] c);
    return c == 3'b000 || c == 3'b001 || c == 3'b010 || c == 3'b011 || c == 3'b101;
  endfunction

  // Behavioural ALU; garbage on illegal codes and eq set whenever the output is zero, so the arbiter's gating is visible.
  function automatic logic [W-1:0] alu_calc(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_out = alu_calc(alu_ctrl, alu_op1, alu_op2);
  assign alu_eq  = (alu_out == '0) || !legal(alu_ctrl);

  function automatic rsp_t exp_rsp(input logic id, input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    rsp_t r;
    r.id     = id;
    r.err    = !legal(c);
    r.result = r.err ? '0 : alu_calc(c, a, b);
    r.eq     = (c == 3'b001) && (a == b);
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ordered list of in-flight ops; head_vis says whether q[0] already sits in the response slot.
  rsp_t q[$];
  bit   head_vis = 1'b0;
  bit   last_g = 1'b1;
  rsp_t obs[$];

  function automatic void predict(output bit r0, output bit r1, output bit mv);
    bit issue_free, g0, g1;
    mv = (q.size() > int'(head_vis)) && (!head_vis || rsp_ready);
    issue_free = (q.size() == int'(head_vis)) || mv;
    g0 = s0_valid && (!s1_valid || last_g);
    g1 = s1_valid && (!s0_valid || !last_g);
    r0 = rst_n && g0 && issue_free;
    r1 = rst_n && g1 && issue_free;
  endfunction

  bit m_r0, m_r1, m_mv, m_dr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      head_vis = 1'b0;
      last_g = 1'b1;
    end else begin
      predict(m_r0, m_r1, m_mv);
      m_dr = head_vis && rsp_ready;
      if (m_dr) void'(q.pop_front());
      head_vis = m_mv ? 1'b1 : (m_dr ? 1'b0 : head_vis);
      if (m_r0) begin
        q.push_back(exp_rsp(1'b0, s0_ctrl, s0_op1, s0_op2));
        last_g = 1'b0;
      end else if (m_r1) begin
        q.push_back(exp_rsp(1'b1, s1_ctrl, s1_op1, s1_op2));
        last_g = 1'b1;
      end
    end
  end

  bit c_r0, c_r1, c_mv;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_s0_ready", W'(s0_ready), 0);
      check("rst_s1_ready", W'(s1_ready), 0);
      check("rst_rsp_valid", W'(rsp_valid), 0);
    end else begin
      predict(c_r0, c_r1, c_mv);
      check("s0_ready", W'(s0_ready), W'(c_r0));
      check("s1_ready", W'(s1_ready), W'(c_r1));
      check("rsp_valid", W'(rsp_valid), W'(head_vis));
      if (head_vis && q.size() > 0) begin
        check("rsp_id", W'(rsp_id), W'(q[0].id));
        check("rsp_result", rsp_result, q[0].result);
        check("rsp_eq", W'(rsp_eq), W'(q[0].eq));
        check("rsp_err", W'(rsp_err), W'(q[0].err));
      end
      if (rsp_valid && rsp_ready) obs.push_back({rsp_id, rsp_result, rsp_eq, rsp_err});
    end
  end

  task automatic send(input bit port, input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc = 1'b0;
    int n = 0;
    if (port) begin s1_valid = 1'b1; s1_ctrl = c; s1_op1 = a; s1_op2 = b; end
    else      begin s0_valid = 1'b1; s0_ctrl = c; s0_op1 = a; s0_op2 = b; end
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = port ? s1_ready : s0_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout port %0d: no ready within 50 cycles, expected an accept", port);
    end
    if (port) s1_valid = 1'b0; else s0_valid = 1'b0;
  endtask

  task automatic stream(input bit port, input int cnt);
    for (int k = 1; k <= cnt; k++) begin
      logic [W-1:0] a;
      a = W'(k * (port ? 10 : 1));
      send(port, 3'b000, a, a);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_obs(input string name, input int idx, input rsp_t e);
    if (idx >= obs.size()) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: response %0d missing (got %0d responses), expected id=%0d result=%0h", name, idx, obs.size(), e.id, e.result);
    end else begin
      check({name, "_id"}, W'(obs[idx].id), W'(e.id));
      check({name, "_result"}, obs[idx].result, e.result);
      check({name, "_eq"}, W'(obs[idx].eq), W'(e.eq));
      check({name, "_err"}, W'(obs[idx].err), W'(e.err));
    end
  endtask

  int b;

  initial begin
    // Reset values
    #12;
    check("reset_rsp_id", W'(rsp_id), 0);
    check("reset_rsp_result", rsp_result, 0);
    check("reset_rsp_eq", W'(rsp_eq), 0);
    check("reset_rsp_err", W'(rsp_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Contention right after reset: grants alternate starting with port 0
    b = obs.size();
    fork
      stream(1'b0, 2);
      stream(1'b1, 2);
    join
    idle(4);
    check_obs("rr0", b,     '{id: 1'b0, result: 32'd2,  eq: 1'b0, err: 1'b0});
    check_obs("rr1", b + 1, '{id: 1'b1, result: 32'd20, eq: 1'b0, err: 1'b0});
    check_obs("rr2", b + 2, '{id: 1'b0, result: 32'd4,  eq: 1'b0, err: 1'b0});
    check_obs("rr3", b + 3, '{id: 1'b1, result: 32'd40, eq: 1'b0, err: 1'b0});

    // Single op and its 2-edge latency
    send(1'b0, 3'b000, 32'd5, 32'd7);
    @(posedge clk); #1;
    check("lat_rsp_valid", W'(rsp_valid), 1);
    check("lat_rsp_result", rsp_result, 32'd12);
    check("lat_rsp_id", W'(rsp_id), 0);
    check("lat_rsp_eq_err", {30'd0, rsp_eq, rsp_err}, 0);
    idle(3);

    // SUB zero flag, and eq suppressed for non-SUB
    b = obs.size();
    send(1'b1, 3'b001, 32'd9, 32'd9);
    send(1'b1, 3'b001, 32'd9, 32'd4);
    send(1'b1, 3'b011, 32'd9, 32'd9);
    send(1'b1, 3'b010, 32'd9, 32'd4);
    send(1'b1, 3'b101, 32'hFFFF_FFFF, 32'd1);
    idle(4);
    check_obs("sub_eq", b,     '{id: 1'b1, result: 32'd0, eq: 1'b1, err: 1'b0});
    check_obs("sub_ne", b + 1, '{id: 1'b1, result: 32'd5, eq: 1'b0, err: 1'b0});
    check_obs("or_eq0", b + 2, '{id: 1'b1, result: 32'd9, eq: 1'b0, err: 1'b0});
    check_obs("and_eq0", b + 3, '{id: 1'b1, result: 32'd0, eq: 1'b0, err: 1'b0});
    check_obs("slt_neg", b + 4, '{id: 1'b1, result: 32'd1, eq: 1'b0, err: 1'b0});

    // Illegal codes, then a legal op clears err
    b = obs.size();
    send(1'b0, 3'b110, 32'd3, 32'd4);
    send(1'b0, 3'b100, 32'd3, 32'd4);
    send(1'b0, 3'b000, 32'd3, 32'd4);
    idle(4);
    check_obs("ill110", b,     '{id: 1'b0, result: 32'd0, eq: 1'b0, err: 1'b1});
    check_obs("ill100", b + 1, '{id: 1'b0, result: 32'd0, eq: 1'b0, err: 1'b1});
    check_obs("legal_after", b + 2, '{id: 1'b0, result: 32'd7, eq: 1'b0, err: 1'b0});

    // Backpressure: two ops fill the pipe, the third stalls; payload holds
    b = obs.size();
    rsp_ready = 1'b0;
    fork
      stream(1'b0, 3);
    join_none
    repeat (6) @(negedge clk);
    check("bp_s0_ready", W'(s0_ready), 0);
    check("bp_s0_valid", W'(s0_valid), 1);
    check("bp_rsp_valid", W'(rsp_valid), 1);
    check("bp_hold_a", rsp_result, 32'd2);
    repeat (3) @(negedge clk);
    check("bp_hold_b", rsp_result, 32'd2);
    check("bp_no_drain", W'(obs.size()), W'(b));
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait fork;
    idle(4);
    check("bp_count", W'(obs.size()), W'(b + 3));
    check_obs("bp0", b,     '{id: 1'b0, result: 32'd2, eq: 1'b0, err: 1'b0});
    check_obs("bp1", b + 1, '{id: 1'b0, result: 32'd4, eq: 1'b0, err: 1'b0});
    check_obs("bp2", b + 2, '{id: 1'b0, result: 32'd6, eq: 1'b0, err: 1'b0});

    // Reset with both stages full
    rsp_ready = 1'b0;
    fork
      send(1'b0, 3'b000, 32'd100, 32'd1);
      send(1'b1, 3'b000, 32'd200, 32'd1);
    join
    check("full_rsp_valid", W'(rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_rsp_valid", W'(rsp_valid), 0);
    check("rst_async_result", rsp_result, 0);
    idle(2);
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    b = obs.size();
    idle(4);
    check("no_stale_rsp", W'(obs.size()), W'(b));
    fork
      send(1'b0, 3'b001, 32'd8, 32'd3);
      send(1'b1, 3'b001, 32'd8, 32'd8);
    join
    idle(4);
    check_obs("post_rst0", b,     '{id: 1'b0, result: 32'd5, eq: 1'b0, err: 1'b0});
    check_obs("post_rst1", b + 1, '{id: 1'b1, result: 32'd0, eq: 1'b1, err: 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
